// File: rtl/uart_core.sv
// Full-duplex UART: 16x baud-tick generator, oversampling receiver, transmitter, FIFOs both ways.
// Compile-time option UART_PARITY_EN inserts one even-parity bit between data and stop bits.

module uart_core_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_wr, do_rd;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_rd   = rd_i && !empty_o;
  // a write into a full FIFO still lands when the same cycle frees a slot
  assign do_wr   = wr_i && (!full_o || do_rd);
  assign wptr_d  = do_wr ? wptr_q + (AW+1)'(1) : wptr_q;
  assign rptr_d  = do_rd ? rptr_q + (AW+1)'(1) : rptr_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
endmodule

module uart_core #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 19200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_write,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_read,
  output logic                 rx_present,
  output logic                 rx_full,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun,
  input  logic                 clear_errors
);
  localparam int DIV = (CLK_HZ + 8*BAUD) / (16*BAUD);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS-1);

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
`ifdef UART_PARITY_EN
    RX_PARITY    = 3'd3,
`endif
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_e;

  logic [BW-1:0] baud_cnt_q;
  logic          tick;

  assign tick = (baud_cnt_q == BW'(DIV-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) baud_cnt_q <= '0;
    else        baud_cnt_q <= tick ? '0 : baud_cnt_q + BW'(1);
  end

  // ---------------- receiver ----------------
  logic [1:0]           rx_sync_q;
  logic                 rx_s;
  rx_state_e            rx_state_q;
  logic [3:0]           rx_tcnt_q;
  logic [3:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_push_q;
  logic                 rx_par_bad_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 rxf_empty, rxf_full;
  logic                 ovr_set;
`ifdef UART_PARITY_EN
  logic                 par_err_q;
`endif

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync_q <= 2'b11;
    else        rx_sync_q <= {rx_sync_q[0], rx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= RX_IDLE;
      rx_tcnt_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_push_q    <= 1'b0;
      rx_par_bad_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      rx_push_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      case (rx_state_q)
        RX_IDLE: begin
          if (tick && !rx_s) begin
            rx_state_q <= RX_START;
            rx_tcnt_q  <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_tcnt_q == 4'd7) begin
              rx_tcnt_q    <= '0;
              rx_bit_q     <= '0;
              rx_par_bad_q <= 1'b0;
              rx_state_q   <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
              rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
              rx_bit_q   <= rx_bit_q + 4'd1;
              if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                rx_state_q <= RX_PARITY;
`else
                rx_state_q <= RX_STOP;
`endif
              end
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
              rx_par_bad_q <= (^rx_shift_q) ^ rx_s;
              rx_state_q   <= RX_STOP;
            end
          end
        end
`endif
        RX_STOP: begin
          if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
              frame_err_q <= !rx_s;
              rx_push_q   <= rx_s && !rx_par_bad_q;
`ifdef UART_PARITY_EN
              par_err_q   <= rx_par_bad_q;
`endif
              rx_state_q  <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_s) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  uart_core_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (rx_push_q),
    .wdata_i (rx_shift_q),
    .rd_i    (rx_read),
    .rdata_o (rx_data),
    .empty_o (rxf_empty),
    .full_o  (rxf_full)
  );

  // a same-cycle read makes room, so only an unserviced push into a full FIFO is lost
  assign ovr_set = rx_push_q && rxf_full && !rx_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overrun_q <= 1'b0;
    else if (ovr_set)      overrun_q <= 1'b1;
    else if (clear_errors) overrun_q <= 1'b0;
  end

  assign rx_present  = !rxf_empty;
  assign rx_full     = rxf_full;
  assign frame_error = frame_err_q;
  assign overrun     = overrun_q;
`ifdef UART_PARITY_EN
  assign parity_error = par_err_q;
`else
  assign parity_error = 1'b0;
`endif

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_q;
  logic [3:0]           tx_tcnt_q;
  logic [3:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_q;
  logic                 txf_empty, txf_full;
  logic [DATA_BITS-1:0] txf_rdata;
  logic                 tx_pop;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  // reload happens from IDLE or on the last tick of STOP, so back-to-back frames have no gap
  assign tx_pop = tick && !txf_empty &&
                  ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && (tx_tcnt_q == 4'd15)));

  uart_core_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (tx_write),
    .wdata_i (tx_data),
    .rd_i    (tx_pop),
    .rdata_o (txf_rdata),
    .empty_o (txf_empty),
    .full_o  (txf_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_shift_q <= txf_rdata;
      tx_q       <= 1'b0;
      tx_tcnt_q  <= '0;
      tx_state_q <= TX_START;
`ifdef UART_PARITY_EN
      tx_par_q   <= ^txf_rdata;
`endif
    end else if (tick) begin
      case (tx_state_q)
        TX_START: begin
          tx_tcnt_q <= tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          tx_tcnt_q <= tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
              tx_q       <= tx_par_q;
              tx_state_q <= TX_PARITY;
`else
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
`endif
            end else begin
              tx_bit_q   <= tx_bit_q + 4'd1;
              tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
              tx_q       <= tx_shift_q[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          tx_tcnt_q <= tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            tx_q       <= 1'b1;
            tx_state_q <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          tx_tcnt_q <= tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) tx_state_q <= TX_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_full = txf_full;
  assign tx_busy = !txf_empty || (tx_state_q != TX_IDLE);
endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: stimulus pushes expected bytes/errors, a monitor pops on rx_present.
// Runs in both default and UART_PARITY_EN builds.

module tb_uart_core;
  localparam int CLK_HZ = 1228800;
  localparam int BAUD   = 19200;
  localparam int DIV    = 4;
  localparam int BITC   = 16 * DIV;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME = (10 + (PAR_EN ? 1 : 0)) * BITC;

  logic       clk, rst_n;
  logic       drv_rx, rx_line, tx;
  logic [7:0] tx_data, rx_data;
  logic       tx_write, tx_full, tx_busy;
  logic       rx_read, rx_present, rx_full;
  logic       frame_error, parity_error, overrun, clear_errors;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0, pe_cnt = 0;
  int exp_fe = 0, exp_pe = 0, exp_ovr = 0;
  bit auto_rd = 1'b0;
  logic [7:0] exp_q[$];

  assign rx_line = tx & drv_rx;

  uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx_line),
    .tx           (tx),
    .tx_data      (tx_data),
    .tx_write     (tx_write),
    .tx_full      (tx_full),
    .tx_busy      (tx_busy),
    .rx_data      (rx_data),
    .rx_read      (rx_read),
    .rx_present   (rx_present),
    .rx_full      (rx_full),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .overrun      (overrun),
    .clear_errors (clear_errors)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
      if (parity_error === 1'b1) pe_cnt <= pe_cnt + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a received byte
  initial begin
    rx_read = 1'b0;
    forever begin
      @(negedge clk);
      rx_read = 1'b0;
      if (rst_n === 1'b1 && auto_rd && rx_present === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected actual=0x%0h expected=none", rx_data);
        end else begin
          chk("rx_byte", int'(rx_data), int'(exp_q.pop_front()));
        end
        rx_read = 1'b1;
      end
    end
  end

  task automatic drive_bit(input logic b);
    drv_rx = b;
    repeat (BITC) @(negedge clk);
  endtask

  // bit-banged frame on the rx pin, with model update from the line rules
  task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit par_flip);
    bit ok;
    ok = stop_b && !(PAR_EN && par_flip);
    if (!stop_b) exp_fe++;
    if (PAR_EN && par_flip) exp_pe++;
    if (ok) begin
      if (!auto_rd && exp_q.size() >= 16) exp_ovr = 1;
      else exp_q.push_back(d);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit((^d) ^ par_flip);
    drive_bit(stop_b);
    drv_rx = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d);
    int n;
    n = 0;
    while (tx_full === 1'b1 && n < 20 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20 * FRAME) chk("tx_full_timeout", n, 0);
    exp_q.push_back(d);
    tx_data  = d;
    tx_write = 1'b1;
    @(negedge clk);
    tx_write = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (tx_busy === 1'b1 && n < 40 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40 * FRAME) chk("tx_idle_timeout", n, 0);
  endtask

  task automatic wait_drained(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    int lat, low, t0, bad;
    logic [7:0] d;
    bit sb, pf;

    rst_n = 1'b0; drv_rx = 1'b1; tx_write = 1'b0; tx_data = '0; clear_errors = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_present", rx_present, 0);
    chk("rst_rx_full", rx_full, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_errs", {frame_error, parity_error}, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // loopback of 0xA5 with start-bit and frame timing
    exp_q.push_back(8'hA5);
    tx_data = 8'hA5; tx_write = 1'b1;
    @(negedge clk);
    tx_write = 1'b0;
    lat = 1;
    while (tx !== 1'b0 && lat < 64) begin @(negedge clk); lat++; end
    chk("tx_fall_latency_in_range", int'(lat >= 1 && lat <= DIV + 1), 1);
    t0 = cyc;
    low = 0;
    while (tx === 1'b0 && low < 200) begin @(negedge clk); low++; end
    chk("start_bit_len", low, BITC);
    while (tx_busy === 1'b1 && cyc - t0 < 3 * FRAME) @(negedge clk);
    chk("frame_len", cyc - t0, FRAME);
    repeat (4) @(negedge clk);
    chk("loop_rx_present", rx_present, 1);
    chk("loop_rx_data", rx_data, 8'hA5);
    auto_rd = 1'b1;
    wait_drained("loop_a5_consumed");

    // false start
    drv_rx = 1'b0;
    repeat (20) @(negedge clk);
    drv_rx = 1'b1;
    repeat (400) @(negedge clk);
    chk("false_start_no_fe", fe_cnt, exp_fe);
    chk("false_start_no_pe", pe_cnt, exp_pe);
    chk("false_start_no_push", rx_present, 0);

    // framing error then a good frame
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("frame_err_pulse", fe_cnt, exp_fe);
    chk("frame_err_no_push", rx_present, 0);
    send_frame(8'h55, 1'b1, 1'b0);
    wait_drained("after_fe_0x55");

    // parity: 0x01 with wrong then right parity bit (no-op frames in default build are good frames)
    if (PAR_EN) begin
      send_frame(8'h01, 1'b1, 1'b1);
      chk("parity_err_pulse", pe_cnt, exp_pe);
      chk("parity_err_no_push", rx_present, 0);
      send_frame(8'h01, 1'b1, 1'b0);
      wait_drained("parity_ok_0x01");
    end

    // randomized loopback traffic
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      write_byte(d);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 700)) @(negedge clk);
    end
    wait_tx_idle();
    repeat (100) @(negedge clk);
    wait_drained("rand_loopback_drained");

    // randomized bit-banged frames with random stop/parity faults
    for (int i = 0; i < 12; i++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      pf = PAR_EN && ($urandom_range(0, 3) == 0);
      send_frame(d, sb, pf);
    end
    wait_drained("rand_rx_drained");
    chk("rand_fe_count", fe_cnt, exp_fe);
    chk("rand_pe_count", pe_cnt, exp_pe);

    // overrun: 17 frames with nobody reading
    auto_rd = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 17; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("ovr_rx_full", rx_full, 1);
    chk("ovr_flag", overrun, exp_ovr);
    chk("ovr_queue_len", exp_q.size(), 16);
    auto_rd = 1'b1;
    wait_drained("ovr_first16_intact");
    chk("ovr_sticky", overrun, 1);
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", overrun, 0);

    // reset during the data bits of the 3rd of 4 queued bytes
    write_byte(8'($urandom_range(0, 255)));
    lat = 0;
    while (tx !== 1'b0 && lat < 64) begin @(negedge clk); lat++; end
    chk("rstmid_first_start_seen", int'(tx === 1'b0), 1);
    for (int i = 0; i < 3; i++) write_byte(8'($urandom_range(0, 255)));
    repeat (2 * FRAME + 200 - 3) @(negedge clk);
    chk("rstmid_two_received", exp_q.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx_high", tx, 1);
    chk("rstmid_tx_busy", tx_busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("rstmid_line_idle", bad, 0);
    chk("rstmid_busy_after", tx_busy, 0);
    chk("rstmid_rx_empty", rx_present, 0);

    chk("final_fe_count", fe_cnt, exp_fe);
    chk("final_pe_count", pe_cnt, exp_pe);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART with an internal 16x baud-tick generator, oversampling receiver, transmitter and FIFOs of configurable depth on both directions. It replaces hand-built baud counters and fixed 8-bit UART instances in top-level designs. It sits between the board `rx`/`tx` pins and on-chip logic such as echo loops, PicoBlaze ports and debug consoles. Baud rate, data width and FIFO depth are set by parameters; optional parity is selected at compile time.

## Interface
- `CLK_HZ`, 100000000: input clock frequency.
- `BAUD`, 19200: line rate. `DIV = (CLK_HZ + 8*BAUD) / (16*BAUD)` (rounded); `DIV` must be ≥ 2.
- `DATA_BITS`, 8: payload bits per frame, range 5..9.
- `FIFO_DEPTH`, 16: entries per FIFO; must be a power of two, ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line in; asynchronous to `clk`.
- `tx`  out  1  serial line out.
- `tx_data`  in  DATA_BITS  byte to transmit.
- `tx_write`  in  1  push `tx_data` into the TX FIFO.
- `tx_full`  out  1  TX FIFO full.
- `tx_busy`  out  1  TX FIFO non-empty or frame in progress.
- `rx_data`  out  DATA_BITS  head of the RX FIFO (first-word fall-through).
- `rx_read`  in  1  pop the RX FIFO.
- `rx_present`  out  1  RX FIFO non-empty.
- `rx_full`  out  1  RX FIFO full.
- `frame_error`  out  1  one-cycle pulse on a bad stop bit.
- `parity_error`  out  1  one-cycle pulse on a parity mismatch.
- `overrun`  out  1  sticky flag; a received frame was dropped because the RX FIFO was full.
- `clear_errors`  in  1  clears `overrun`.

## Operation
- **Baud generator:** counter runs 0..DIV-1. `tick` is high for one cycle when the count wraps. One bit lasts 16 ticks.
- **RX input:** `rx` passes through a 2-flop synchronizer; its idle value is 1.
- **RX states:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE → START when the synchronized line is 0 on a tick.
  - START samples the line at tick 8. If the sample is 1, it is a false start → IDLE. Otherwise → DATA.
  - DATA samples every 16 ticks, LSB first, `DATA_BITS` samples.
  - PARITY is entered only when the parity feature is compiled in.
  - STOP samples at mid-bit.
    - Sample 1 with no parity error: push the byte → IDLE.
    - Sample 0: `frame_error` pulses, the byte is discarded → WAIT_HIGH.
  - WAIT_HIGH → IDLE when the line is 1.
- **RX push into a full FIFO:**
  - If `rx_read` is not asserted in the same cycle, the byte is dropped and `overrun` is set.
  - If `rx_read` is asserted in the same cycle, the pop and push both occur and `overrun` is not set.
- **TX states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a tick while the TX FIFO is non-empty. The head is popped into the shift register at that point.
  - START drives 0 for 16 ticks.
  - DATA shifts out LSB first.
  - STOP drives 1 for 16 ticks. Then the FSM reloads directly if the FIFO is non-empty, with no idle gap; otherwise → IDLE.
- **FIFO edge cases:**
  - `tx_write` while `tx_full` is ignored.
  - `rx_read` while `!rx_present` is ignored.
  - Simultaneous write and read on a full FIFO: both take effect; occupancy is unchanged.
- **Flags:** `clear_errors` together with a new overrun in the same cycle leaves `overrun` = 1 (set wins).
- **Reset (async, `rst_n` = 0):**
  - `tx` = 1.
  - Both FIFOs empty: `rx_present` = 0, `tx_full` = 0, `rx_full` = 0, `tx_busy` = 0.
  - All error flags = 0; `rx_data` = 0.
  - Both FSMs in IDLE; baud counter = 0.
  - A frame in flight is abandoned.

## Timing
- `tx` is registered. It falls 1 cycle after the tick that starts a frame, so it falls at most DIV+1 cycles after a `tx_write` into an idle core.
- Frame length = (1 + DATA_BITS + P + 1) × 16 × DIV cycles, where P = 1 with parity and 0 without.
- RX latency: push occurs 1 cycle after the stop-bit sample. `rx_present` and `rx_data` are valid on the following cycle.
- Error pulses are coincident with the push cycle.
- FIFO flags update the cycle after the write or read.

## Configuration
- Macro: `UART_PARITY_EN`.
- **Defined:** one even-parity bit follows the data bits.
  - TX generates it.
  - RX checks it. On a mismatch, `parity_error` pulses and the byte is discarded. The stop bit is still checked, and a bad stop bit also pulses `frame_error`.
- **Undefined:** no parity bit and no PARITY states. `parity_error` is tied to 0.

## Test plan
All scenarios use CLK_HZ=1228800, BAUD=19200, so DIV=4 and one bit = 64 cycles. DATA_BITS=8, FIFO_DEPTH=16.

1. **Loopback:** `tx` looped to `rx`; write 0xA5 → `tx` low for exactly 64 cycles (start bit), frame = 640 cycles without parity; `rx_data` = 0xA5 with `rx_present` = 1; `tx_busy` drops after the stop bit.
2. **False start:** drive `rx` low for 20 cycles, then high → no push, no error pulses, RX returns to IDLE.
3. **Framing error:** send 0x3C with a stop bit of 0 → `frame_error` pulses once, `rx_present` stays 0. The next valid frame 0x55 is received correctly.
4. **Overrun:** send 17 frames without reading → first 16 bytes read back intact, `overrun` = 1; `clear_errors` → `overrun` = 0.
5. **Parity:**
   - With `UART_PARITY_EN`: 0x01 sent with parity bit 0 → `parity_error` pulse, no push; 0x01 with parity bit 1 → received.
   - Without `UART_PARITY_EN`: frame = 640 cycles.
6. **Reset mid-frame:** assert `rst_n` = 0 during the data bits of the 3rd of 4 queued TX bytes → `tx` = 1 immediately, `tx_busy` = 0; after release, the line stays idle.
